barker_spreader: RTL and testbench
==================================

// Module: barker_spreader
// PURPOSE
//  DSSS spreading stage directly downstream of dbpsk_modulator in the 802.11b backscatter tag path.
//  Takes the differentially encoded DBPSK symbol stream and spreads each symbol into an 11-chip Barker sequence.
//  Output is a registered chip stream for the switch-drive logic.
//  Emits a one-cycle strobe at each symbol boundary so the upstream chain (data_source/whitening/dbpsk) can advance in lock-step.
// PARAMETERS
//  CHIPS     11              chips per symbol (>=2)
//  BARKER    11'b10110111000 spreading code, MSB = first chip out (802.11b +1-1+1+1-1+1+1+1-1-1-1, 1=+1)
//  CHIP_DIV  1               clock cycles per chip (>=1)
// PORTS
//  clock          in   1  chip-rate reference clock (main_clock output)
//  reset          in   1  synchronous, active-high
//  trigger        in   1  level; high = transmit, low = stop at next symbol boundary
//  input_dbpsk    in   1  current DBPSK symbol from dbpsk_modulator
//  output_chip    out  1  spread chip = BARKER[chip] XOR symbol, registered
//  chip_valid     out  1  high while output_chip carries a live chip
//  symbol_strobe  out  1  1-cycle pulse on the edge that samples input_dbpsk (chip 0 of each symbol)
//  busy           out  1  high in SPREAD state
// BEHAVIOUR
//  Reset
//   - Every clock edge with reset=1 forces: state=IDLE; counters=0; sym_reg=0; all outputs 0.
//   - Reset overrides all other inputs, including mid-symbol; no partial symbol is resumed afterwards.
//  Counters
//   - div_cnt counts 0..CHIP_DIV-1; chip_idx counts 0..CHIPS-1.
//   - Widths are $clog2 of the respective range, minimum 1 bit.
//   - Both wrap to 0; no other values are reachable.
//  FSM: IDLE
//   - Outputs output_chip=0, chip_valid=0, busy=0, symbol_strobe=0.
//   - Edge with trigger=1: sym_reg<=input_dbpsk; output_chip<=BARKER[CHIPS-1]^input_dbpsk; chip_valid<=1; busy<=1; symbol_strobe<=1.
//     chip_idx<=0, div_cnt<=0, state -> SPREAD.
//   - Latency: first chip is visible one cycle after trigger is sampled high.
//  FSM: SPREAD
//   - Each chip is held for exactly CHIP_DIV cycles; div_cnt increments each edge.
//   - At div_cnt=CHIP_DIV-1 with chip_idx<CHIPS-1: chip_idx++; output_chip<=BARKER[CHIPS-2-chip_idx]^sym_reg.
//   - At last cycle of last chip (chip_idx=CHIPS-1, div_cnt=CHIP_DIV-1), trigger=1:
//     back-to-back, no gap; resample input_dbpsk as in IDLE entry; symbol_strobe<=1; stay SPREAD.
//   - Same point with trigger=0: state -> IDLE; chip_valid, busy, output_chip <= 0.
//   - symbol_strobe is 0 on every other edge.
//   - trigger falling mid-symbol does not truncate the symbol; the remaining chips complete.
//   - trigger glitch low then high within a symbol has no effect.
//   - input_dbpsk is ignored except on strobe edges; sym_reg is constant for a whole symbol.
//  Timing and period
//   - Symbol period is exactly CHIPS*CHIP_DIV cycles.
//   - Upstream must update input_dbpsk on or after the strobe and hold it stable until the next strobe edge.
//  Invariants
//   - chip_valid == busy at all times.
//   - output_chip is 0 whenever chip_valid=0.
// TESTING
//  1. CHIP_DIV=1, input_dbpsk=0, trigger held 1 from cycle 0
//     -> cycles 1..11 chips 1,0,1,1,0,1,1,1,0,0,0, repeating with period 11.
//     -> symbol_strobe high at cycles 1,12,23.
//  2. Same, input_dbpsk=1 -> chips 0,1,0,0,1,0,0,0,1,1,1 per symbol.
//     Toggling input_dbpsk at a strobe flips polarity of exactly the next symbol only.
//  3. trigger drops while chip 4 is out -> chips 5..10 still output.
//     -> chip_valid=0 the cycle after chip 10; no further strobe.
//  4. reset pulsed for 1 cycle while chip 5 is out -> all outputs 0 next cycle.
//     -> trigger still 1 restarts at chip 0 with a fresh strobe one cycle after reset deasserts.
//  5. CHIP_DIV=4, input_dbpsk=0 -> each chip held 4 cycles (1,1,1,1,0,0,0,0,...).
//     -> strobe every 44 cycles; chip_valid never drops between symbols.
//  6. Random trigger/input_dbpsk over 10k cycles vs. reference model
//     -> output_chip, strobe timing and invariants (chip_valid==busy, chip=0 when invalid) match every cycle.

Source files
------------

// File: rtl/barker_spreader.sv
// Barker DSSS spreader: expands each DBPSK symbol into CHIPS registered chips,
// each held CHIP_DIV clock cycles, with a strobe marking every symbol start.
//
// Handshake: there is no valid/ready pair on the input side. symbol_strobe is
// the consume signal. input_dbpsk is sampled on the same edge that raises
// symbol_strobe. Upstream advances on seeing the strobe and holds its symbol
// stable until the next strobe edge. chip_valid marks live chips and cannot be
// stalled.
module barker_spreader #(
    parameter int               CHIPS    = 11,
    parameter logic [CHIPS-1:0] BARKER   = 11'b10110111000,
    parameter int               CHIP_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    input  logic input_dbpsk,
    output logic output_chip,
    output logic chip_valid,
    output logic symbol_strobe,
    output logic busy
);

    localparam int DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int IDX_W = (CHIPS > 1) ? $clog2(CHIPS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHIPS - 1);

    // BARKER is written first-chip-in-MSB. This reverses it so that
    // CODE[chip_idx] is the chip for that index.
    function automatic logic [CHIPS-1:0] reverse_code(input logic [CHIPS-1:0] code);
        logic [CHIPS-1:0] r;
        for (int i = 0; i < CHIPS; i++) begin
            r[i] = code[CHIPS-1-i];
        end
        return r;
    endfunction

    localparam logic [CHIPS-1:0] CODE = reverse_code(BARKER);

    typedef enum logic {
        IDLE   = 1'b0,
        SPREAD = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [IDX_W-1:0] chip_idx, idx_next, idx_inc;
    logic             sym_reg, sym_next;
    logic             chip_reg, chip_next;
    logic             valid_reg, valid_next;
    logic             strobe_reg, strobe_next;
    logic             start;

    // Next-state logic: start a symbol from IDLE or back-to-back, or step chips and divider.
    always_comb begin
        state_next  = state;
        div_next    = div_cnt;
        idx_next    = chip_idx;
        sym_next    = sym_reg;
        chip_next   = chip_reg;
        valid_next  = valid_reg;
        strobe_next = 1'b0;
        start       = 1'b0;
        idx_inc     = chip_idx + 1'b1;
        case (state)
            IDLE: begin
                start = trigger;
            end
            SPREAD: begin
                if (div_cnt == DIV_LAST) begin
                    div_next = '0;
                    if (chip_idx != IDX_LAST) begin
                        idx_next  = idx_inc;
                        chip_next = CODE[idx_inc] ^ sym_reg;
                    end else if (trigger) begin
                        start = 1'b1;
                    end else begin
                        // The symbol is finished and trigger is low, so go
                        // quiet. A low trigger earlier in the symbol does
                        // not matter.
                        state_next = IDLE;
                        idx_next   = '0;
                        chip_next  = 1'b0;
                        valid_next = 1'b0;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (start) begin
            state_next  = SPREAD;
            div_next    = '0;
            idx_next    = '0;
            sym_next    = input_dbpsk;
            chip_next   = CODE[0] ^ input_dbpsk;
            valid_next  = 1'b1;
            strobe_next = 1'b1;
        end
    end

    // State and registered outputs. A synchronous reset abandons any partial symbol.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            chip_idx   <= '0;
            sym_reg    <= 1'b0;
            chip_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            strobe_reg <= 1'b0;
        end else begin
            state      <= state_next;
            div_cnt    <= div_next;
            chip_idx   <= idx_next;
            sym_reg    <= sym_next;
            chip_reg   <= chip_next;
            valid_reg  <= valid_next;
            strobe_reg <= strobe_next;
        end
    end

    assign output_chip   = chip_reg;
    assign chip_valid    = valid_reg;
    assign symbol_strobe = strobe_reg;
    assign busy          = (state == SPREAD);

endmodule

// File: tb/tb_barker_spreader.sv
// Bench for barker_spreader: a CHIP_DIV=1 and a CHIP_DIV=4 instance share inputs
// and are tracked every cycle by a symbol-position reference model.
module tb_barker_spreader;

    localparam int CHIPS = 11;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       trigger;
    logic       input_dbpsk;
    logic [1:0] o_chip;
    logic [1:0] o_valid;
    logic [1:0] o_strobe;
    logic [1:0] o_busy;

    barker_spreader #(.CHIPS(11), .BARKER(11'b10110111000), .CHIP_DIV(1)) u1 (
        .clock(clock), .reset(reset), .trigger(trigger), .input_dbpsk(input_dbpsk),
        .output_chip(o_chip[0]), .chip_valid(o_valid[0]),
        .symbol_strobe(o_strobe[0]), .busy(o_busy[0])
    );

    barker_spreader #(.CHIPS(11), .BARKER(11'b10110111000), .CHIP_DIV(4)) u4 (
        .clock(clock), .reset(reset), .trigger(trigger), .input_dbpsk(input_dbpsk),
        .output_chip(o_chip[1]), .chip_valid(o_valid[1]),
        .symbol_strobe(o_strobe[1]), .busy(o_busy[1])
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    bit bk[CHIPS] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the cycle position within the current symbol. The chip is
    // bk[pos / div] ^ symbol.
    int m_div[2] = '{1, 4};
    bit m_act[2];
    int m_pos[2];
    bit m_sym[2];
    bit m_stb[2];

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            m_stb[d] = 1'b0;
            if (reset) begin
                m_act[d] = 1'b0;
                m_pos[d] = 0;
                m_sym[d] = 1'b0;
            end else if (!m_act[d]) begin
                if (trigger) begin
                    m_act[d] = 1'b1;
                    m_pos[d] = 0;
                    m_sym[d] = input_dbpsk;
                    m_stb[d] = 1'b1;
                end
            end else begin
                m_pos[d]++;
                if (m_pos[d] == CHIPS * m_div[d]) begin
                    if (trigger) begin
                        m_pos[d] = 0;
                        m_sym[d] = input_dbpsk;
                        m_stb[d] = 1'b1;
                    end else begin
                        m_act[d] = 1'b0;
                        m_pos[d] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic model_chip(input int d);
        return m_act[d] ? (bk[m_pos[d] / m_div[d]] ^ m_sym[d]) : 1'b0;
    endfunction

    // ---------------- driver: one clock with model compare ----------------
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("model_chip[%0d]", d),   o_chip[d],   model_chip(d));
            check($sformatf("model_valid[%0d]", d),  o_valid[d],  m_act[d]);
            check($sformatf("model_busy[%0d]", d),   o_busy[d],   m_act[d]);
            check($sformatf("model_strobe[%0d]", d), o_strobe[d], m_stb[d]);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic trig;
        logic din;
        logic chip;
        logic strobe;
        logic valid;
    } vec_t;

    vec_t vecs[23];

    initial begin
        int vcnt;
        int scnt;
        int drops;
        int s_at[$];

        reset       = 1'b1;
        trigger     = 1'b0;
        input_dbpsk = 1'b0;
        step();
        step();
        check("reset_chip",   o_chip[0],   1'b0);
        check("reset_valid",  o_valid[0],  1'b0);
        check("reset_strobe", o_strobe[0], 1'b0);
        check("reset_busy",   o_busy[0],   1'b0);
        reset = 1'b0;

        // Symbol 0 uses din=0, symbol 1 uses din=1, then din returns to 0.
        // din changes mid-symbol 1 are ignored.
        for (int k = 0; k < 11; k++)
            vecs[k] = '{1'b1, (k == 0) ? 1'b0 : 1'b1, bk[k], (k == 0), 1'b1};
        for (int k = 11; k < 22; k++)
            vecs[k] = '{1'b1, (k == 11) ? 1'b1 : 1'b0, ~bk[k-11], (k == 11), 1'b1};
        vecs[22] = '{1'b1, 1'b0, bk[0], 1'b1, 1'b1};

        for (int k = 0; k < 23; k++) begin
            trigger     = vecs[k].trig;
            input_dbpsk = vecs[k].din;
            step();
            check($sformatf("vec%0d_chip", k),   o_chip[0],   vecs[k].chip);
            check($sformatf("vec%0d_strobe", k), o_strobe[0], vecs[k].strobe);
            check($sformatf("vec%0d_valid", k),  o_valid[0],  vecs[k].valid);
        end

        // Drop trigger while chip 4 is out; chips 5..10 must still appear.
        for (int i = 0; i < 4; i++) step();
        trigger = 1'b0;
        vcnt = 0;
        scnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_valid[0]) vcnt++;
            if (o_strobe[0]) scnt++;
        end
        check_int("drop_tail_chips", vcnt, 6);
        check_int("drop_no_strobe", scnt, 0);
        check("drop_idle_valid", o_valid[0], 1'b0);

        // Reset while chip 5 is out, then restart with trigger still high.
        trigger = 1'b1;
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        check("midrst_chip",   o_chip[0],   1'b0);
        check("midrst_valid",  o_valid[0],  1'b0);
        check("midrst_busy",   o_busy[0],   1'b0);
        check("midrst_strobe", o_strobe[0], 1'b0);
        reset = 1'b0;
        step();
        check("restart_strobe", o_strobe[0], 1'b1);
        check("restart_chip",   o_chip[0],   1'b1);
        check("restart_valid",  o_valid[0],  1'b1);

        // For CHIP_DIV=4, each chip is held 4 cycles and there is a strobe every 44 cycles.
        reset = 1'b1;
        step();
        reset       = 1'b0;
        trigger     = 1'b1;
        input_dbpsk = 1'b0;
        drops = 0;
        for (int c = 1; c <= 88; c++) begin
            step();
            if (o_strobe[1]) s_at.push_back(c);
            if (!o_valid[1]) drops++;
            check($sformatf("div4_chip_c%0d", c), o_chip[1], bk[((c - 1) / 4) % CHIPS]);
        end
        check_int("div4_strobe_count", s_at.size(), 2);
        if (s_at.size() == 2) begin
            check_int("div4_strobe_first", s_at[0], 1);
            check_int("div4_strobe_second", s_at[1], 45);
        end
        check_int("div4_valid_drops", drops, 0);

        // Random trigger/din with rare resets, checked against the model every cycle.
        for (int i = 0; i < 10000; i++) begin
            trigger     = ($urandom_range(0, 9) < 7);
            input_dbpsk = 1'($urandom_range(0, 1));
            reset       = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
